// File: rtl/nec_ir_receiver.sv
// NEC IR frame decoder: measures mark/space widths of the synchronized ir_rx line and checks leader, 32 LSB-first bits and stop burst.
// Define NEC_REPEAT_EN to add repeat-code detection (rpt pulse); otherwise a repeat-length leader space is reported as err.
module nec_ir_receiver #(
  parameter logic [19:0] LEAD_MARK_MIN    = 20'd400000,
  parameter logic [19:0] LEAD_MARK_MAX    = 20'd500000,
  parameter logic [19:0] LEAD_SPACE_MIN   = 20'd200000,
  parameter logic [19:0] LEAD_SPACE_MAX   = 20'd250000,
  parameter logic [19:0] RPT_SPACE_MIN    = 20'd100000,
  parameter logic [19:0] RPT_SPACE_MAX    = 20'd125000,
  parameter logic [19:0] BIT_MARK_MIN     = 20'd20000,
  parameter logic [19:0] BIT_MARK_MAX     = 20'd40000,
  parameter logic [19:0] BIT_SPACE_THRESH = 20'd56250,
  parameter logic [19:0] BIT_SPACE_MAX    = 20'd100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ir_rx,
  output logic [7:0] addr,
  output logic [7:0] cmd,
  output logic       valid,
  output logic       rpt,
  output logic       err,
  output logic       busy,
  output logic [2:0] rx_status
);

  typedef enum logic [2:0] {
    RX_IDLE       = 3'd0,
    RX_LEAD_MARK  = 3'd1,
    RX_LEAD_SPACE = 3'd2,
    RX_BIT_MARK   = 3'd3,
    RX_BIT_SPACE  = 3'd4,
    RX_STOP_MARK  = 3'd5,
    RX_RPT_MARK   = 3'd6
  } rx_state_t;

  rx_state_t   state_reg;
  logic        sync1_reg, ir_s_reg, ir_d_reg;
  logic [19:0] cnt_reg;
  logic [31:0] shreg_reg;
  logic [5:0]  bit_cnt_reg;
  logic [7:0]  addr_reg, cmd_reg;
  logic        valid_reg, err_reg;
  logic        fall, rise;
  logic        lead_mark_ok, lead_space_ok, rpt_space_ok;
  logic        bit_mark_ok, bit_space_ok, frame_ok;

  // Idle line is high, so the synchronizer resets to 1 to avoid a false fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      ir_s_reg  <= 1'b1;
      ir_d_reg  <= 1'b1;
    end else begin
      sync1_reg <= ir_rx;
      ir_s_reg  <= sync1_reg;
      ir_d_reg  <= ir_s_reg;
    end
  end

  assign fall = ir_d_reg & ~ir_s_reg;
  assign rise = ~ir_d_reg & ir_s_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (state_reg == RX_IDLE || fall || rise) begin
      cnt_reg <= '0;
    end else if (cnt_reg != '1) begin
      cnt_reg <= cnt_reg + 20'd1;
    end
  end

  assign lead_mark_ok  = (cnt_reg >= LEAD_MARK_MIN)  && (cnt_reg <= LEAD_MARK_MAX);
  assign lead_space_ok = (cnt_reg >= LEAD_SPACE_MIN) && (cnt_reg <= LEAD_SPACE_MAX);
  assign rpt_space_ok  = (cnt_reg >= RPT_SPACE_MIN)  && (cnt_reg <= RPT_SPACE_MAX);
  assign bit_mark_ok   = (cnt_reg >= BIT_MARK_MIN)   && (cnt_reg <= BIT_MARK_MAX);
  assign bit_space_ok  = (cnt_reg >= BIT_MARK_MIN)   && (cnt_reg <= BIT_SPACE_MAX);
  assign frame_ok      = (shreg_reg[15:8] == ~shreg_reg[7:0]) &&
                         (shreg_reg[31:24] == ~shreg_reg[23:16]);

`ifdef NEC_REPEAT_EN
  logic rpt_reg;
  logic have_frame_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= RX_IDLE;
      shreg_reg      <= '0;
      bit_cnt_reg    <= '0;
      addr_reg       <= '0;
      cmd_reg        <= '0;
      valid_reg      <= 1'b0;
      err_reg        <= 1'b0;
`ifdef NEC_REPEAT_EN
      rpt_reg        <= 1'b0;
      have_frame_reg <= 1'b0;
`endif
    end else begin
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
`ifdef NEC_REPEAT_EN
      rpt_reg   <= 1'b0;
`endif
      case (state_reg)
        RX_IDLE: begin
          if (fall) state_reg <= RX_LEAD_MARK;
        end
        RX_LEAD_MARK: begin
          if (rise) begin
            if (lead_mark_ok) begin
              state_reg <= RX_LEAD_SPACE;
            end else begin
              err_reg   <= 1'b1;
              state_reg <= RX_IDLE;
            end
          end else if (cnt_reg > LEAD_MARK_MAX) begin
            err_reg   <= 1'b1;
            state_reg <= RX_IDLE;
          end
        end
        RX_LEAD_SPACE: begin
          if (fall) begin
            if (lead_space_ok) begin
              bit_cnt_reg <= '0;
              state_reg   <= RX_BIT_MARK;
`ifdef NEC_REPEAT_EN
            end else if (rpt_space_ok) begin
              state_reg <= RX_RPT_MARK;
`else
            end else if (rpt_space_ok) begin
              err_reg   <= 1'b1;
              state_reg <= RX_IDLE;
`endif
            end else begin
              err_reg   <= 1'b1;
              state_reg <= RX_IDLE;
            end
          end else if (cnt_reg > LEAD_SPACE_MAX) begin
            err_reg   <= 1'b1;
            state_reg <= RX_IDLE;
          end
        end
        RX_BIT_MARK: begin
          if (rise) begin
            if (bit_mark_ok) begin
              state_reg <= RX_BIT_SPACE;
            end else begin
              err_reg   <= 1'b1;
              state_reg <= RX_IDLE;
            end
          end else if (cnt_reg > BIT_MARK_MAX) begin
            err_reg   <= 1'b1;
            state_reg <= RX_IDLE;
          end
        end
        RX_BIT_SPACE: begin
          if (fall) begin
            if (bit_space_ok) begin
              // Bits arrive LSB first, so shifting in from the top leaves bit 0 at shreg[0].
              shreg_reg   <= {(cnt_reg >= BIT_SPACE_THRESH), shreg_reg[31:1]};
              bit_cnt_reg <= bit_cnt_reg + 6'd1;
              state_reg   <= (bit_cnt_reg == 6'd31) ? RX_STOP_MARK : RX_BIT_MARK;
            end else begin
              err_reg   <= 1'b1;
              state_reg <= RX_IDLE;
            end
          end else if (cnt_reg > BIT_SPACE_MAX) begin
            err_reg   <= 1'b1;
            state_reg <= RX_IDLE;
          end
        end
        RX_STOP_MARK: begin
          if (rise) begin
            if (bit_mark_ok && frame_ok) begin
              addr_reg       <= shreg_reg[7:0];
              cmd_reg        <= shreg_reg[23:16];
              valid_reg      <= 1'b1;
`ifdef NEC_REPEAT_EN
              have_frame_reg <= 1'b1;
`endif
            end else begin
              err_reg <= 1'b1;
            end
            state_reg <= RX_IDLE;
          end else if (cnt_reg > BIT_MARK_MAX) begin
            err_reg   <= 1'b1;
            state_reg <= RX_IDLE;
          end
        end
        RX_RPT_MARK: begin
`ifdef NEC_REPEAT_EN
          if (rise) begin
            if (bit_mark_ok && have_frame_reg) rpt_reg <= 1'b1;
            else                               err_reg <= 1'b1;
            state_reg <= RX_IDLE;
          end else if (cnt_reg > BIT_MARK_MAX) begin
            err_reg   <= 1'b1;
            state_reg <= RX_IDLE;
          end
`else
          state_reg <= RX_IDLE;
`endif
        end
        default: state_reg <= RX_IDLE;
      endcase
    end
  end

  assign addr      = addr_reg;
  assign cmd       = cmd_reg;
  assign valid     = valid_reg;
  assign err       = err_reg;
  assign busy      = (state_reg != RX_IDLE);
  assign rx_status = state_reg;
`ifdef NEC_REPEAT_EN
  assign rpt = rpt_reg;
`else
  assign rpt = 1'b0;
`endif

endmodule

// File: tb/tb_nec_ir_receiver.sv
// Directed bench for nec_ir_receiver with all timing parameters scaled down by 1000.
// Pulse counters are kept by a negedge monitor; expected values are hand-computed.
module tb_nec_ir_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ir_rx = 1'b1;
  logic [7:0] addr, cmd;
  logic       valid, rpt, err, busy;
  logic [2:0] rx_status;

  // Scaled nominal durations: 9 ms, 4.5 ms, 2.25 ms, 562.5 us, 1.6875 ms
  localparam int LM = 450, LS = 225, RS = 112, BM = 28, S0 = 28, S1 = 84;

  int checks = 0, errors = 0;
  int n_valid = 0, n_rpt = 0, n_err = 0;
  int sv, sr, se;
  logic prev_any = 1'b0;

  always #10 clk = ~clk;

  nec_ir_receiver #(
    .LEAD_MARK_MIN(20'd400), .LEAD_MARK_MAX(20'd500),
    .LEAD_SPACE_MIN(20'd200), .LEAD_SPACE_MAX(20'd250),
    .RPT_SPACE_MIN(20'd100), .RPT_SPACE_MAX(20'd125),
    .BIT_MARK_MIN(20'd20), .BIT_MARK_MAX(20'd40),
    .BIT_SPACE_THRESH(20'd56), .BIT_SPACE_MAX(20'd100)
  ) dut (
    .clk(clk), .rst(rst), .ir_rx(ir_rx),
    .addr(addr), .cmd(cmd), .valid(valid), .rpt(rpt), .err(err),
    .busy(busy), .rx_status(rx_status)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid || rpt || err) begin
      check("pulse_excl", 32'(valid) + 32'(rpt) + 32'(err), 1);
      check("pulse_width", 32'(prev_any), 0);
    end
    if (valid) n_valid <= n_valid + 1;
    if (rpt)   n_rpt   <= n_rpt + 1;
    if (err)   n_err   <= n_err + 1;
    prev_any <= valid | rpt | err;
  end

  task automatic hold(input logic level, input int n);
    ir_rx = level;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      hold(1'b0, BM);
      hold(1'b1, w[i] ? S1 : S0);
    end
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] c, input logic [7:0] ic);
    hold(1'b0, LM);
    hold(1'b1, LS);
    send_bits({ic, c, ~a, a}, 32);
    hold(1'b0, BM);
    ir_rx = 1'b1;
  endtask

  task automatic send_repeat();
    hold(1'b0, LM);
    hold(1'b1, RS);
    hold(1'b0, BM);
    ir_rx = 1'b1;
  endtask

  task automatic snap();
    sv = n_valid; sr = n_rpt; se = n_err;
  endtask

  task automatic check_deltas(input string tag, input int dv, input int dr, input int de);
    check({tag, "_valid"}, n_valid - sv, dv);
    check({tag, "_rpt"},   n_rpt - sr,   dr);
    check({tag, "_err"},   n_err - se,   de);
    $display("%s: valid+%0d rpt+%0d err+%0d addr=%02h cmd=%02h",
             tag, n_valid - sv, n_rpt - sr, n_err - se, addr, cmd);
  endtask

  initial begin
    hold(1'b1, 5);
    check("rst_addr", addr, 0);
    check("rst_cmd", cmd, 0);
    check("rst_valid", valid, 0);
    check("rst_rpt", rpt, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_status", rx_status, 0);
    rst = 1'b0;
    hold(1'b1, 20);

    // Repeat code with no prior frame
    snap();
    send_repeat();
    hold(1'b1, 20);
    check_deltas("rpt_after_rst", 0, 0, 1);

    // Nominal frame, with exact 3-edge latency on valid
    snap();
    send_frame(8'h5A, 8'h3C, 8'hC3);
    @(negedge clk); check("lat_e1", valid, 0);
    @(negedge clk); check("lat_e2", valid, 0);
    @(negedge clk); check("lat_e3", valid, 1);
    @(negedge clk); check("lat_e4", valid, 0);
    hold(1'b1, 20);
    check_deltas("nominal", 1, 0, 0);
    check("nominal_addr", addr, 8'h5A);
    check("nominal_cmd", cmd, 8'h3C);

    // Corrupted inverted command
    snap();
    send_frame(8'h5A, 8'h3C, 8'hC4);
    hold(1'b1, 20);
    check_deltas("bad_inv", 0, 0, 1);
    check("bad_inv_addr", addr, 8'h5A);
    check("bad_inv_cmd", cmd, 8'h3C);

    // Valid frame, then repeat code after 40 ms (scaled)
    snap();
    send_frame(8'h81, 8'h42, 8'hBD);
    hold(1'b1, 2000);
    check_deltas("frame2", 1, 0, 0);
    snap();
    send_repeat();
    hold(1'b1, 20);
`ifdef NEC_REPEAT_EN
    check_deltas("repeat", 0, 1, 0);
`else
    check_deltas("repeat", 0, 0, 1);
`endif
    check("repeat_addr", addr, 8'h81);
    check("repeat_cmd", cmd, 8'h42);

    // Line stuck low: err on the 505th edge after the drop
    snap();
    ir_rx = 1'b0;
    repeat (504) @(negedge clk);
    check("tmo_err_early", err, 0);
    check("tmo_busy_early", busy, 1);
    @(negedge clk);
    check("tmo_err", err, 1);
    check("tmo_busy", busy, 0);
    @(negedge clk);
    check("tmo_err_once", err, 0);
    hold(1'b0, 94);
    hold(1'b1, 20);
    check_deltas("timeout", 0, 0, 1);

    // Reset during the space of bit 17
    snap();
    hold(1'b0, LM);
    hold(1'b1, LS);
    send_bits({8'h00, 8'hFF, 8'hFE, 8'h01}, 17);
    hold(1'b0, BM);
    hold(1'b1, 10);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_status", rx_status, 0);
    check("rst_mid_busy", busy, 0);
    rst = 1'b0;
    hold(1'b1, 200);
    check_deltas("rst_mid", 0, 0, 0);
    check("rst_mid_addr", addr, 0);

    snap();
    send_frame(8'h01, 8'hFF, 8'h00);
    hold(1'b1, 20);
    check_deltas("after_rst", 1, 0, 0);
    check("after_rst_addr", addr, 8'h01);
    check("after_rst_cmd", cmd, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
